ni_inject: RTL and testbench

Network-interface injection block for the synchronous diagonal mesh NoC. It accepts packets from the local core with absolute destination coordinates and computes the per-packet direction sign bits. Packets are buffered in a small FIFO and presented to the router's local input port (the one feeding `r_block`) over a valid/ready handshake. Destinations outside the mesh are consumed and dropped, and each drop is counted.

---
 rtl/ni_inject_pkg.sv | 33 +++
 rtl/ni_inject_if.sv | 34 +++
 rtl/ni_inject_sync_fifo.sv | 99 +++++++++
 rtl/ni_inject.sv | 99 +++++++++
 tb/tb_ni_inject.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ni_inject_pkg.sv
// Shared NoC parameters and types for the network-interface injection path.
package ni_inject_pkg;

  // Mesh is MESH_SIDE x MESH_SIDE routers; coordinates are absolute.
  localparam int MESH_SIDE = 3;
  localparam int CW        = $clog2(MESH_SIDE);

  // Header carried alongside each payload. The sign bits are computed
  // once at injection so the router does not need to know its own
  // position relative to the destination.
  typedef struct packed {
    logic [$clog2(MESH_SIDE)-1:0] dest_x, dest_y;
    logic                         s_delta_x, s_delta_y;
  } noc_hdr_t;

  localparam int NOC_HDR_W = $bits(noc_hdr_t);

  // Occupancy classification of a FIFO, decoded from its count.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  // A coordinate pair is legal when both lie inside the mesh. The compare
  // is done one bit wider so a power-of-two MESH_SIDE cannot wrap to 0.
  function automatic logic in_mesh(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] side;
    side = MESH_SIDE[CW:0];
    return ({1'b0, x} < side) && ({1'b0, y} < side);
  endfunction

endpackage

// File: rtl/ni_inject_if.sv
// Core-side and router-side valid/ready handshake of the injection block.
// slave is the view of ni_inject; master is the view of whatever drives it.
interface ni_inject_if #(
  parameter int DATA_W = 32
);
  import ni_inject_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_dest_x;
  logic [CW-1:0]     in_dest_y;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_dest_x;
  logic [CW-1:0]     out_dest_y;
  logic              out_s_delta_x;
  logic              out_s_delta_y;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_dest_x, in_dest_y, in_data, out_ready,
    output in_ready, out_valid, out_dest_x, out_dest_y,
           out_s_delta_x, out_s_delta_y, out_data
  );

  modport master (
    output in_valid, in_dest_x, in_dest_y, in_data, out_ready,
    input  in_ready, out_valid, out_dest_x, out_dest_y,
           out_s_delta_x, out_s_delta_y, out_data
  );

endinterface

// File: rtl/ni_inject_sync_fifo.sv
// Show-ahead synchronous FIFO with power-of-two depth.
//
// state        | meaning
// -------------+-----------------------------------------------
// FIFO_EMPTY   | count == 0, head is not valid
// FIFO_PARTIAL | 0 < count < DEPTH, push and pop both allowed
// FIFO_FULL    | count == DEPTH, pushes are ignored
//
// The state is decoded from the registered count rather than held in a
// separate register, so it can never disagree with the pointers.
module sync_fifo
  import ni_inject_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_state_e      state;
  logic             push_en;
  logic             pop_en;

  // Classify occupancy and compute next pointers/count.
  always_comb begin
    state    = FIFO_PARTIAL;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (count_q == '0) begin
      state = FIFO_EMPTY;
    end else if (count_q == DEPTH_C) begin
      state = FIFO_FULL;
    end

    // A full FIFO refuses a push even when it is popped in the same cycle,
    // which keeps the upstream ready free of any dependency on pop.
    push_en = push_i && (state != FIFO_FULL);
    pop_en  = pop_i  && (state != FIFO_EMPTY);

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset so it has none.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (state == FIFO_FULL);
  assign empty_o = (state == FIFO_EMPTY);
  assign count_o = count_q;

endmodule

// File: rtl/ni_inject.sv
// Network-interface injection: checks the destination against the mesh,
// computes the direction sign bits, counts dropped packets and queues
// legal packets for the local router input.
module ni_inject
  import ni_inject_pkg::*;
#(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ni_inject_if.slave    ni,
  output logic [7:0]    drop_cnt
);

  localparam int            ENTRY_W = NOC_HDR_W + DATA_W;
  localparam int            CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] X_C     = CW'(X_COORD);
  localparam logic [CW-1:0] Y_C     = CW'(Y_COORD);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  noc_hdr_t           wr_hdr;
  noc_hdr_t           rd_hdr;
  logic [DATA_W-1:0]  rd_data;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               legal;
  logic               accept;
  logic               push;
  logic               pop;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  // Legality, sign bits and handshake qualification for the incoming packet.
  always_comb begin
    legal            = in_mesh(ni.in_dest_x, ni.in_dest_y);
    wr_hdr           = '0;
    wr_hdr.dest_x    = ni.in_dest_x;
    wr_hdr.dest_y    = ni.in_dest_y;
    wr_hdr.s_delta_x = (ni.in_dest_x < X_C);
    wr_hdr.s_delta_y = (ni.in_dest_y < Y_C);
    accept           = ni.in_valid && ni.in_ready;
    push             = accept && legal;
    pop              = ni.out_valid && ni.out_ready;
  end

  // Illegal packets are handshaken and discarded; the count sticks at 255.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !legal && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({wr_hdr, ni.in_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {rd_hdr, rd_data} = fifo_rdata;

  // Both ready and valid come from registered occupancy only, so there is
  // no combinational path from out_ready to in_ready and no bypass.
  assign ni.in_ready      = !fifo_full;
  assign ni.out_valid     = !fifo_empty;
  assign ni.out_dest_x    = rd_hdr.dest_x;
  assign ni.out_dest_y    = rd_hdr.dest_y;
  assign ni.out_s_delta_x = rd_hdr.s_delta_x;
  assign ni.out_s_delta_y = rd_hdr.s_delta_y;
  assign ni.out_data      = rd_data;
  assign drop_cnt         = drop_cnt_q;

  // Occupancy must never exceed the depth and the flags must track it.
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_count <= DEPTH_C) && (fifo_full == (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_ni_inject.sv
// Directed bench for ni_inject on a 3x3 mesh, router at (1,1), depth 4.
module tb_ni_inject;
  import ni_inject_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] drop_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  ni_inject_if #(.DATA_W(32)) nif ();

  ni_inject #(
    .X_COORD (1),
    .Y_COORD (1),
    .DATA_W  (32),
    .DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ni       (nif),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y, input logic [31:0] d);
    nif.in_valid  = v;
    nif.in_dest_x = x[CW-1:0];
    nif.in_dest_y = y[CW-1:0];
    nif.in_data   = d;
  endtask

  // Compares {valid, dest_x, dest_y, sdx, sdy, data} of the head in one go.
  task automatic chk_out(input string tag, input int x, input int y,
                         input logic sx, input logic sy, input logic [31:0] d);
    logic [CW-1:0] ex, ey;
    ex = x[CW-1:0];
    ey = y[CW-1:0];
    chk(tag, {nif.out_valid, nif.out_dest_x, nif.out_dest_y,
              nif.out_s_delta_x, nif.out_s_delta_y, nif.out_data},
             {1'b1, ex, ey, sx, sy, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    int ex, ey;
    logic acc;

    // Reset held for two cycles.
    rst_n         = 1'b0;
    nif.out_ready = 1'b0;
    drive(1'b0, 0, 0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", nif.out_valid, 1'b0);
    chk("rst_in_ready", nif.in_ready, 1'b1);
    chk("rst_drop_cnt", drop_cnt, 8'd0);

    // Sign sweep: every destination, drained as fast as it is injected.
    nif.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i / 3, i % 3, 32'hA000 + i);
      tick();
      chk_out("sweep", i / 3, i % 3, (i / 3) == 0, (i % 3) == 0, 32'hA000 + i);
    end
    drive(1'b0, 0, 0, 32'h0);
    tick();
    chk("sweep_drain", nif.out_valid, 1'b0);

    // Fill with the router stalled.
    nif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i % 3, 2, 32'hB000 + i);
      chk("bp_ready_pre", nif.in_ready, 1'b1);
      tick();
    end
    chk("bp_ready_full", nif.in_ready, 1'b0);
    drive(1'b1, 0, 1, 32'hB004);
    tick();
    chk_out("bp_stall_a", 0, 2, 1'b1, 1'b0, 32'hB000);
    tick();
    chk_out("bp_stall_b", 0, 2, 1'b1, 1'b0, 32'hB000);
    chk("bp_ready_hold", nif.in_ready, 1'b0);

    // Release and collect all five in order.
    nif.out_ready = 1'b1;
    k   = 0;
    cyc = 0;
    while (k < 5 && cyc < 20) begin
      if (nif.out_valid) begin
        ex = (k == 4) ? 0 : k % 3;
        ey = (k == 4) ? 1 : 2;
        chk_out("bp_order", ex, ey, ex == 0, ey == 0, 32'hB000 + k);
        k++;
      end
      acc = nif.in_valid && nif.in_ready;
      tick();
      if (acc) drive(1'b0, 0, 0, 32'h0);
      cyc++;
    end
    if (k != 5) chk("bp_timeout", k, 5);
    chk("bp_drained", nif.out_valid, 1'b0);

    // Illegal destinations are dropped, the legal one goes through.
    drive(1'b1, 3, 1, 32'hC000);
    tick();
    chk("ill_drop1", drop_cnt, 8'd1);
    chk("ill_nout1", nif.out_valid, 1'b0);
    drive(1'b1, 1, 3, 32'hC001);
    tick();
    chk("ill_drop2", drop_cnt, 8'd2);
    chk("ill_nout2", nif.out_valid, 1'b0);
    drive(1'b1, 2, 0, 32'hC002);
    tick();
    chk("ill_drop_keep", drop_cnt, 8'd2);
    chk_out("ill_legal", 2, 0, 1'b0, 1'b1, 32'hC002);
    drive(1'b0, 0, 0, 32'h0);
    tick();
    chk("ill_drained", nif.out_valid, 1'b0);

    // Drop counter saturation: starts at 2.
    drive(1'b1, 3, 3, 32'hDEAD);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 251) chk("sat_254", drop_cnt, 8'd254);
    end
    chk("sat_255", drop_cnt, 8'd255);
    chk("sat_nout", nif.out_valid, 1'b0);
    drive(1'b0, 0, 0, 32'h0);

    // Simultaneous push and pop at count 2.
    nif.out_ready = 1'b0;
    drive(1'b1, 0, 0, 32'hD000);
    tick();
    drive(1'b1, 1, 1, 32'hD001);
    tick();
    drive(1'b1, 2, 2, 32'hD002);
    chk("pp_count_pre", dut.u_fifo.count_o, 3'd2);
    nif.out_ready = 1'b1;
    tick();
    chk("pp_count_same", dut.u_fifo.count_o, 3'd2);
    chk_out("pp_head", 1, 1, 1'b0, 1'b0, 32'hD001);
    drive(1'b1, 0, 2, 32'hD003);
    nif.out_ready = 1'b0;
    tick();
    chk("pp_count_3", dut.u_fifo.count_o, 3'd3);

    // Reset in the middle of traffic, with an offer still pending.
    rst_n = 1'b0;
    drive(1'b1, 1, 0, 32'hD004);
    tick();
    chk("mrst_out_valid", nif.out_valid, 1'b0);
    chk("mrst_in_ready", nif.in_ready, 1'b1);
    chk("mrst_drop_cnt", drop_cnt, 8'd0);
    chk("mrst_count", dut.u_fifo.count_o, 3'd0);
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 32'h0);
    tick();
    chk("mrst_no_stale", nif.out_valid, 1'b0);
    nif.out_ready = 1'b1;
    drive(1'b1, 1, 2, 32'hE000);
    tick();
    chk_out("mrst_fresh", 1, 2, 1'b0, 1'b0, 32'hE000);
    drive(1'b0, 0, 0, 32'h0);
    tick();
    chk("mrst_drained", nif.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
